// File: rtl/router_src_arb.sv
// router_src_arb: round-robin arbiter for three byte-stream sources feeding a router port.
// Appends an XOR parity byte to each packet and discards packets addressed to port 3.
module router_src_arb #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       req_2,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic       busy,
  output logic       ack_0,
  output logic       ack_1,
  output logic       ack_2,
  output logic [2:0] gnt,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       done,
  output logic       drop
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, PAY, PAR, GAP, DISC
  } state_t;

  state_t        state, state_n;
  logic [2:0]    gnt_n;
  logic          pv_n;
  logic [7:0]    din_n;
  logic          done_n, drop_n;
  logic          pending, pend_n;
  logic [7:0]    parity, par_n;
  logic [5:0]    count, cnt_n;
  logic [1:0]    last, last_n;
  logic [GW-1:0] gcnt, gcnt_n;

  logic [2:0] req;
  logic [1:0] win;
  logic [7:0] data_g;
  logic [5:0] len;
  logic       bad;
  logic       load_ok;
  logic       ack;
  logic       load;

  assign req     = {req_2, req_1, req_0};
  assign len     = data_g[7:2];
  assign bad     = &data_g[1:0];
  assign load_ok = !pending || !busy;

  assign data_g = ({8{gnt[0]}} & data_0)
                | ({8{gnt[1]}} & data_1)
                | ({8{gnt[2]}} & data_2);

  assign ack_0 = resetn & ack & gnt[0];
  assign ack_1 = resetn & ack & gnt[1];
  assign ack_2 = resetn & ack & gnt[2];

  // search starts one past the most recently granted source
  always_comb begin
    win = 2'd0;
    unique case (last)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    pv_n    = pkt_valid;
    din_n   = data_in;
    done_n  = 1'b0;
    drop_n  = 1'b0;
    par_n   = parity;
    cnt_n   = count;
    last_n  = last;
    gcnt_n  = gcnt;
    ack     = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = 3'b001 << win;
          last_n  = win;
          state_n = HDR;
        end
      end
      HDR: begin
        if (bad) begin
          ack     = 1'b1;
          cnt_n   = len;
          state_n = DISC;
        end else if (load_ok) begin
          ack     = 1'b1;
          load    = 1'b1;
          din_n   = data_g;
          pv_n    = 1'b1;
          par_n   = data_g;
          cnt_n   = len;
          state_n = (len != 6'd0) ? PAY : PAR;
        end
      end
      PAY: begin
        if (load_ok) begin
          ack   = 1'b1;
          load  = 1'b1;
          din_n = data_g;
          par_n = parity ^ data_g;
          cnt_n = count - 6'd1;
          if (count == 6'd1) state_n = PAR;
        end
      end
      PAR: begin
        if (load_ok) begin
          load    = 1'b1;
          din_n   = parity;
          pv_n    = 1'b0;
          gcnt_n  = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        // gap timing starts only once the router has taken the parity byte
        if (!pending) begin
          if (gcnt == GLAST) begin
            done_n  = 1'b1;
            gnt_n   = '0;
            state_n = IDLE;
          end else begin
            gcnt_n = gcnt + GW'(1);
          end
        end
      end
      DISC: begin
        if (count != 6'd0) begin
          ack   = 1'b1;
          cnt_n = count - 6'd1;
        end
        if (count <= 6'd1) begin
          drop_n  = 1'b1;
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    pend_n = load | (pending & busy);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= '0;
      pkt_valid <= 1'b0;
      data_in   <= '0;
      done      <= 1'b0;
      drop      <= 1'b0;
      pending   <= 1'b0;
      parity    <= '0;
      count     <= '0;
      last      <= 2'd2;
      gcnt      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      pkt_valid <= pv_n;
      data_in   <= din_n;
      done      <= done_n;
      drop      <= drop_n;
      pending   <= pend_n;
      parity    <= par_n;
      count     <= cnt_n;
      last      <= last_n;
      gcnt      <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_router_src_arb.sv
// tb_router_src_arb: vector table, corner sequences and random packets
// checked against a packet-level round-robin/parity model.
module tb_router_src_arb;
  localparam int G = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req_0, req_1, req_2;
  logic [7:0] data_0, data_1, data_2;
  logic       busy;
  logic       ack_0, ack_1, ack_2;
  logic [2:0] gnt;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       done, drop;

  always #5 clock = ~clock;

  router_src_arb #(.GAP_CYCLES(G)) dut (
    .clock(clock), .resetn(resetn),
    .req_0(req_0), .req_1(req_1), .req_2(req_2),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .busy(busy),
    .ack_0(ack_0), .ack_1(ack_1), .ack_2(ack_2),
    .gnt(gnt), .pkt_valid(pkt_valid), .data_in(data_in),
    .done(done), .drop(drop)
  );

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] seed;
  } pkt_t;

  typedef struct {
    logic [2:0] gnt;
    logic       pv;
    logic [7:0] din;
    logic       done;
    logic       drop;
    logic [2:0] ack;
  } snap_t;

  typedef struct {
    int         src;
    logic [7:0] hdr;
    logic [7:0] seed;
    int         busy_pct;
    logic [2:0] exp_gnt;
    int         exp_done;
    int         exp_drop;
    int         exp_bytes;
  } vec_t;

  logic [7:0] srcq [3][$];
  pkt_t       pkq [3][$];
  logic [8:0] exp_stream[$];
  logic [8:0] got_stream[$];
  logic [2:0] exp_grants[$];
  logic [2:0] got_grants[$];
  snap_t      hist[$];
  int exp_done, exp_drop;
  int done_cnt, drop_cnt, proto_err;
  int ack_cnt [3];
  int m_last;
  logic tb_pend;
  logic [2:0] prev_gnt;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] pay(input logic [7:0] seed, input int k);
    return 8'(int'(seed) * 13 + k * 29 + 7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add_pkt(input int n, input logic [7:0] hdr,
                         input logic [7:0] seed);
    pkt_t p;
    p.hdr  = hdr;
    p.seed = seed;
    pkq[n].push_back(p);
    srcq[n].push_back(hdr);
    for (int k = 0; k < int'(hdr[7:2]); k++)
      srcq[n].push_back(pay(seed, k));
  endtask

  task automatic drive_src();
    req_0  = (srcq[0].size() != 0);
    req_1  = (srcq[1].size() != 0);
    req_2  = (srcq[2].size() != 0);
    data_0 = req_0 ? srcq[0][0] : 8'h00;
    data_1 = req_1 ? srcq[1][0] : 8'h00;
    data_2 = req_2 ? srcq[2][0] : 8'h00;
  endtask

  // one clock: drive, sample acks, take edge, update sources and monitor
  task automatic cyc(input logic b);
    logic [2:0] a;
    logic       pvb, ld;
    logic [7:0] dinb;
    snap_t      s;
    busy = b;
    drive_src();
    #1;
    a    = {ack_2, ack_1, ack_0};
    pvb  = pkt_valid;
    dinb = data_in;
    if (((a & ~gnt) != 3'b000) || ($countones(a) > 1)) proto_err++;
    @(posedge clock);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (a[n]) begin
        if (srcq[n].size() > 0) void'(srcq[n].pop_front());
        ack_cnt[n]++;
      end
    end
    ld = ((|a) && (pvb || pkt_valid)) || (pvb && !pkt_valid);
    if (!b && tb_pend) begin
      got_stream.push_back({pvb, dinb});
      tb_pend = 1'b0;
    end
    if (ld) tb_pend = 1'b1;
    if (done) done_cnt++;
    if (drop) drop_cnt++;
    if (prev_gnt == 3'b000 && gnt != 3'b000) got_grants.push_back(gnt);
    prev_gnt = gnt;
    s.gnt  = gnt;
    s.pv   = pkt_valid;
    s.din  = data_in;
    s.done = done;
    s.drop = drop;
    s.ack  = a;
    hist.push_back(s);
    @(negedge clock);
  endtask

  task automatic clear_mon();
    exp_stream.delete();
    got_stream.delete();
    exp_grants.delete();
    got_grants.delete();
    hist.delete();
    exp_done  = 0;
    exp_drop  = 0;
    done_cnt  = 0;
    drop_cnt  = 0;
    proto_err = 0;
    for (int n = 0; n < 3; n++) ack_cnt[n] = 0;
  endtask

  task automatic flush_src();
    for (int n = 0; n < 3; n++) begin
      srcq[n].delete();
      pkq[n].delete();
    end
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    flush_src();
    cyc(1'b0);
    cyc(1'b0);
    resetn   = 1'b1;
    m_last   = 2;
    tb_pend  = 1'b0;
    prev_gnt = 3'b000;
    clear_mon();
  endtask

  // packet-level model: round robin over sources holding packets,
  // header/payload/parity stream for good packets, drop for addr 3
  task automatic build_expected();
    int         w;
    int         idx;
    pkt_t       p;
    logic [7:0] par;
    logic [7:0] b;
    while (pkq[0].size() + pkq[1].size() + pkq[2].size() > 0) begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (w < 0 && pkq[idx].size() > 0) w = idx;
      end
      p = pkq[w].pop_front();
      m_last = w;
      exp_grants.push_back(3'b001 << w);
      if (p.hdr[1:0] == 2'b11) begin
        exp_drop++;
      end else begin
        par = p.hdr;
        exp_stream.push_back({1'b1, p.hdr});
        for (int k = 0; k < int'(p.hdr[7:2]); k++) begin
          b = pay(p.seed, k);
          par = par ^ b;
          exp_stream.push_back({1'b1, b});
        end
        exp_stream.push_back({1'b0, par});
        exp_done++;
      end
    end
  endtask

  function automatic bit idle_now();
    return srcq[0].size() == 0 && srcq[1].size() == 0 &&
           srcq[2].size() == 0 && gnt == 3'b000 &&
           (done_cnt + drop_cnt) >= (exp_done + exp_drop);
  endfunction

  task automatic run_until_idle(input int budget, input int pct);
    int i;
    i = 0;
    while (!idle_now()) begin
      if (i >= budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: %0d cycles, done+drop %0d want %0d",
                 i, done_cnt + drop_cnt, exp_done + exp_drop);
        break;
      end
      cyc($urandom_range(99) < pct);
      i++;
    end
  endtask

  task automatic compare_results(input string nm);
    int m;
    chk({nm, " ngrants"}, got_grants.size(), exp_grants.size());
    m = (got_grants.size() < exp_grants.size()) ?
        got_grants.size() : exp_grants.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s grant%0d", nm, i), 32'(got_grants[i]),
          32'(exp_grants[i]));
    chk({nm, " nbytes"}, got_stream.size(), exp_stream.size());
    m = (got_stream.size() < exp_stream.size()) ?
        got_stream.size() : exp_stream.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s byte%0d", nm, i), 32'(got_stream[i]),
          32'(exp_stream[i]));
    chk({nm, " done"}, done_cnt, exp_done);
    chk({nm, " drop"}, drop_cnt, exp_drop);
    chk({nm, " ackrule"}, proto_err, 0);
  endtask

  vec_t tbl [7];
  logic [2:0] gexp [6];

  initial begin
    logic [7:0] par;
    int viol;
    int np;

    tbl[0] = '{1, 8'h22, 8'h11, 0,  3'b010, 1, 0, 10};
    tbl[1] = '{0, 8'h01, 8'h00, 0,  3'b001, 1, 0, 2};
    tbl[2] = '{2, 8'h0F, 8'h03, 0,  3'b100, 0, 1, 0};
    tbl[3] = '{0, 8'hFC, 8'h5A, 40, 3'b001, 1, 0, 65};
    tbl[4] = '{2, 8'h03, 8'h00, 0,  3'b100, 0, 1, 0};
    tbl[5] = '{1, 8'h15, 8'hC3, 50, 3'b010, 1, 0, 7};
    tbl[6] = '{0, 8'hFF, 8'h77, 0,  3'b001, 0, 1, 0};
    gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    resetn = 1'b0;
    busy   = 1'b0;
    req_0 = 0; req_1 = 0; req_2 = 0;
    data_0 = 0; data_1 = 0; data_2 = 0;
    tb_pend  = 1'b0;
    prev_gnt = 3'b000;
    m_last   = 2;
    clear_mon();
    @(negedge clock);
    reset_dut();

    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst pv", 32'(pkt_valid), 32'h0);
    chk("rst din", 32'(data_in), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst drop", 32'(drop), 32'h0);

    for (int i = 0; i < 7; i++) begin
      clear_mon();
      add_pkt(tbl[i].src, tbl[i].hdr, tbl[i].seed);
      build_expected();
      run_until_idle(400, tbl[i].busy_pct);
      compare_results($sformatf("vec%0d", i));
      chk($sformatf("vec%0d gnt", i),
          32'(got_grants.size() > 0 ? got_grants[0] : 3'b000),
          32'(tbl[i].exp_gnt));
      chk($sformatf("vec%0d ndone", i), done_cnt, tbl[i].exp_done);
      chk($sformatf("vec%0d ndrop", i), drop_cnt, tbl[i].exp_drop);
      chk($sformatf("vec%0d nbytes", i), got_stream.size(),
          tbl[i].exp_bytes);
    end

    // full packet timing with no backpressure
    reset_dut();
    add_pkt(1, 8'h22, 8'h05);
    build_expected();
    run_until_idle(100, 0);
    compare_results("seqA");
    chk("seqA cycles", hist.size(), 11 + G + 1);
    if (hist.size() == 11 + G + 1) begin
      chk("seqA gnt", 32'(hist[0].gnt), 32'h2);
      chk("seqA pv0", 32'(hist[0].pv), 32'h0);
      chk("seqA hdr", 32'(hist[1].din), 32'h22);
      chk("seqA hdrpv", 32'(hist[1].pv), 32'h1);
      par = 8'h22;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("seqA p%0d", k), 32'(hist[2 + k].din),
            32'(pay(8'h05, k)));
        chk($sformatf("seqA pv%0d", k), 32'(hist[2 + k].pv), 32'h1);
        par = par ^ pay(8'h05, k);
      end
      chk("seqA par", 32'(hist[10].din), 32'(par));
      chk("seqA parpv", 32'(hist[10].pv), 32'h0);
      for (int k = 1; k <= G; k++)
        chk($sformatf("seqA gap%0d", k), 32'(hist[10 + k].done), 32'h0);
      chk("seqA donepulse", 32'(hist[11 + G].done), 32'h1);
      chk("seqA gntoff", 32'(hist[11 + G].gnt), 32'h0);
    end

    // three busy cycles in the middle of the payload
    reset_dut();
    add_pkt(1, 8'h22, 8'h09);
    build_expected();
    for (int i = 0; i < 10; i++) cyc(i >= 5 && i <= 7);
    run_until_idle(100, 0);
    compare_results("seqB");
    chk("seqB acks", ack_cnt[1], 9);
    if (hist.size() > 8) begin
      for (int i = 5; i <= 7; i++) begin
        chk($sformatf("seqB ack%0d", i), 32'(hist[i].ack), 32'h0);
        chk($sformatf("seqB hold%0d", i), 32'(hist[i].din),
            32'(pay(8'h09, 2)));
      end
      chk("seqB resume", 32'(hist[8].din), 32'(pay(8'h09, 3)));
    end

    // all sources requesting continuously
    reset_dut();
    for (int n = 0; n < 3; n++) begin
      add_pkt(n, 8'h08 | 8'(n), 8'(n + 1));
      add_pkt(n, 8'h10 | 8'(n), 8'(n + 7));
    end
    build_expected();
    run_until_idle(300, 0);
    compare_results("seqC");
    chk("seqC ngrants", got_grants.size(), 6);
    if (got_grants.size() == 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("seqC rr%0d", i), 32'(got_grants[i]), 32'(gexp[i]));

    // discarded packet, then another source granted
    reset_dut();
    add_pkt(2, 8'h0F, 8'h03);
    exp_done = 1;
    exp_drop = 1;
    cyc(1'b0);
    add_pkt(0, 8'h04, 8'h21);
    run_until_idle(100, 0);
    chk("seqD ack2", ack_cnt[2], 4);
    chk("seqD drop", drop_cnt, 1);
    chk("seqD done", done_cnt, 1);
    chk("seqD ngrants", got_grants.size(), 2);
    if (got_grants.size() == 2) begin
      chk("seqD g0", 32'(got_grants[0]), 32'h4);
      chk("seqD g1", 32'(got_grants[1]), 32'h1);
    end
    viol = 0;
    foreach (hist[i])
      if (hist[i].gnt == 3'b100 && (hist[i].pv || hist[i].din != 8'h00))
        viol++;
    chk("seqD quiet", viol, 0);
    par = 8'h04 ^ pay(8'h21, 0);
    chk("seqD nbytes", got_stream.size(), 3);
    if (got_stream.size() == 3) begin
      chk("seqD b0", 32'(got_stream[0]), 32'h104);
      chk("seqD b1", 32'(got_stream[1]), 32'({1'b1, pay(8'h21, 0)}));
      chk("seqD b2", 32'(got_stream[2]), 32'({1'b0, par}));
    end

    // zero-length packet
    reset_dut();
    add_pkt(0, 8'h01, 8'h00);
    build_expected();
    run_until_idle(100, 0);
    compare_results("seqE");
    if (hist.size() > 2) begin
      chk("seqE hdr", 32'({hist[1].pv, hist[1].din}), 32'h101);
      chk("seqE par", 32'({hist[2].pv, hist[2].din}), 32'h001);
    end

    // reset in the middle of the payload
    reset_dut();
    add_pkt(1, 8'h22, 8'h44);
    for (int i = 0; i < 4; i++) cyc(1'b0);
    chk("seqF inpay", 32'(pkt_valid), 32'h1);
    resetn = 1'b0;
    cyc(1'b0);
    chk("seqF rstack", 32'(hist[hist.size() - 1].ack), 32'h0);
    chk("seqF gnt", 32'(gnt), 32'h0);
    chk("seqF pv", 32'(pkt_valid), 32'h0);
    chk("seqF din", 32'(data_in), 32'h0);
    chk("seqF done", 32'(done), 32'h0);
    chk("seqF drop", 32'(drop), 32'h0);
    resetn = 1'b1;
    flush_src();
    clear_mon();
    m_last  = 2;
    tb_pend = 1'b0;
    add_pkt(2, 8'h04, 8'h01);
    add_pkt(0, 8'h08, 8'h02);
    build_expected();
    run_until_idle(200, 0);
    compare_results("seqF");
    chk("seqF first", 32'(got_grants.size() > 0 ? got_grants[0] : 3'b000),
        32'h1);

    // random packets with random backpressure
    reset_dut();
    for (int r = 0; r < 5; r++) begin
      clear_mon();
      for (int n = 0; n < 3; n++) begin
        np = $urandom_range(0, 3);
        for (int j = 0; j < np; j++)
          add_pkt(n, 8'($urandom), 8'($urandom));
      end
      if (pkq[0].size() + pkq[1].size() + pkq[2].size() == 0)
        add_pkt(1, 8'($urandom), 8'($urandom));
      build_expected();
      run_until_idle(4000, 30);
      compare_results($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
